demux1_2_stream: RTL and testbench
==================================

Name: demux1_2_stream

Overview:
- 16-bit 1-to-2 demultiplexer with valid/ready handshakes; the inverse of the team's 2:1 word mux.
- Steers one producer stream to consumer A or consumer B according to a per-word select bit.
- Each destination has its own small FIFO, so a stalled consumer never blocks words bound for the other.
- Sits between the result-producing datapath and two downstream sinks, e.g. register-file writeback and the memory store path.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, entries per destination FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_sel  input  1  destination of the current word: 0 = A, 1 = B.
- in_data  input  WIDTH  producer word.
- in_ready  output  1  the word is accepted this cycle if in_valid is also high.
- a_valid  output  1  FIFO A head is valid.
- a_data  output  WIDTH  FIFO A head word.
- a_ready  input  1  consumer A takes the head.
- b_valid  output  1  FIFO B head is valid.
- b_data  output  WIDTH  FIFO B head word.
- b_ready  input  1  consumer B takes the head.

Behaviour:
- Reset (clk edge with rst=1):
  - pointers and counts cleared;
  - a_valid = b_valid = 0;
  - a_data = b_data = 0, with storage cleared;
  - in-flight words are dropped;
  - reset mid-transfer aborts with no partial push.
  - rst has priority over push and pop in the same cycle.
- Push:
  - in_ready = ~full of the FIFO selected by in_sel, combinational from in_sel and the count.
  - A word is pushed into that FIFO when in_valid & in_ready.
  - in_sel and in_data are meaningful only while in_valid = 1.
- Pop: FIFO X pops when x_valid & x_ready. x_valid = (count_x != 0). x_data = the head entry, stable while x_valid=1 and x_ready=0.
- Latency: a word accepted at edge N is visible on x_valid/x_data after edge N. There is no same-cycle bypass, even when the FIFO is empty.
- Ordering: words to the same destination leave in acceptance order. There is no ordering guarantee between A and B.
- Full FIFO:
  - in_ready = 0 for that select only, even if that FIFO pops in the same cycle (no pass-through when full).
  - The producer holds in_valid, in_sel and in_data stable until acceptance.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Empty FIFO: x_valid = 0, and x_ready is ignored.
- Pointers: log2(DEPTH)-bit, wrapping modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Independence: the FIFO not selected is unaffected by in_* and keeps popping normally.

Optional Feature:
- Macro: DEMUX1_2_STATS_EN.
- Defined:
  - adds outputs cnt_a and cnt_b, each 16 bits;
  - each counts accepted pushes to its destination, wraps at 0xFFFF to 0, and is cleared by rst;
  - adds output stall, 1 bit, registered, = 1 for the cycle after any cycle with in_valid & ~in_ready.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (demux_pkg):
  - constants DEST_A = 1'b0, DEST_B = 1'b1;
  - default WIDTH = 16;
  - pointer-width function clog2.
- Sub-module demux_fifo, instantiated twice:
  - ports: clk, rst, push, push_data, pop, full, empty, head_data;
  - holds the storage, pointers and count.
- Top level holds the select steering, in_ready generation and the optional stats.

Test Plan:
- Reset and routing:
  - Stimulus: rst for 2 cycles, then push 0x1234 with sel=0 and 0xABCD with sel=1, with a_ready = b_ready = 1.
  - Required: after reset all outputs are 0. 0x1234 appears on a_data and 0xABCD on b_data one cycle after each acceptance. Each valid is high for exactly one cycle.
- Backpressure on A:
  - Stimulus: a_ready=0; push sel=0 words 0x0001, 0x0002, 0x0003.
  - Required: first two accepted; in_ready=0 on the third until a_ready=1. Output order is 0x0001, 0x0002, 0x0003.
- Independence:
  - Stimulus: FIFO A full with a_ready=0; push sel=1 0x00B1.
  - Required: in_ready=1 and b_data=0x00B1 next cycle. A is unchanged.
- Full with simultaneous pop:
  - Stimulus: A full and a_ready=1 in the same cycle as a sel=0 push.
  - Required: in_ready=0 and no push. The next cycle in_ready=1 and the push is accepted.
- Reset mid-operation:
  - Stimulus: both FIFOs hold 1 word; assert rst together with in_valid=1.
  - Required: next cycle a_valid = b_valid = 0, nothing pushed, counters (if DEMUX1_2_STATS_EN) = 0.
- Stats wrap (DEMUX1_2_STATS_EN):
  - Stimulus: preload via 65536 accepted sel=0 pushes with a_ready=1.
  - Required: cnt_a returns to 0x0000, cnt_b = 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1:2 stream demultiplexer: destination encoding,
// default word width and the pointer-width helper.
package demux_pkg;

    typedef enum logic {
        DEST_A = 1'b0,
        DEST_B = 1'b1
    } dest_e;

    localparam int unsigned DEF_WIDTH = 16;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Per-destination FIFO: registered storage, wrapping pointers and an occupancy
// count. The head word is read straight from storage, so there is no bypass path.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full      = (count == (AW+1)'(DEPTH));
        empty     = (count == '0);
        do_push   = push & ~full;
        do_pop    = pop & ~empty;
        head_data = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux1_2_stream.sv
// 1-to-2 valid/ready demultiplexer with an independent FIFO per destination.
// Optional push counters and stall flag are enabled by defining DEMUX1_2_STATS_EN.
module demux1_2_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready
`ifdef DEMUX1_2_STATS_EN
    ,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b,
    output logic             stall
`endif
);

    logic a_full, a_empty, b_full, b_empty;
    logic push_a, push_b, pop_a, pop_b;
    logic accept;

    // Readiness looks only at the selected FIFO's full flag; a pop in the same
    // cycle does not open a slot for the incoming word.
    always_comb begin
        in_ready = (in_sel == DEST_B) ? ~b_full : ~a_full;
        accept   = in_valid & in_ready;
        push_a   = accept & (in_sel == DEST_A);
        push_b   = accept & (in_sel == DEST_B);
        a_valid  = ~a_empty;
        b_valid  = ~b_empty;
        pop_a    = a_valid & a_ready;
        pop_b    = b_valid & b_ready;
    end

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (push_a),
        .push_data (in_data),
        .pop       (pop_a),
        .full      (a_full),
        .empty     (a_empty),
        .head_data (a_data)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (push_b),
        .push_data (in_data),
        .pop       (pop_b),
        .full      (b_full),
        .empty     (b_empty),
        .head_data (b_data)
    );

`ifdef DEMUX1_2_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
            stall <= 1'b0;
        end else begin
            if (push_a) cnt_a <= cnt_a + 16'd1;
            if (push_b) cnt_b <= cnt_b + 16'd1;
            stall <= in_valid & ~in_ready;
        end
    end
`endif

endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed table-driven bench for demux1_2_stream; the stats checks are compiled
// in when DEMUX1_2_STATS_EN is defined.
module tb_demux1_2_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sel;
    logic [15:0] in_data;
    logic        in_ready;
    logic        a_valid;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [15:0] b_data;
    logic        b_ready;
`ifdef DEMUX1_2_STATS_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic        stall;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    demux1_2_stream #(
        .WIDTH (16),
        .DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_ready (in_ready),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready)
`ifdef DEMUX1_2_STATS_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .stall    (stall)
`endif
    );

    // Inputs for one cycle plus the outputs expected just before its rising edge.
    typedef struct {
        logic        iv;
        logic        sel;
        logic [15:0] d;
        logic        ar;
        logic        br;
        logic        ir;
        logic        av;
        logic [15:0] ad;
        logic        bv;
        logic [15:0] bd;
        logic        dchk;
    } vec_t;

    vec_t vec [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic sel, input logic [15:0] d,
                         input logic ar, input logic br);
        rst      = r;
        in_valid = iv;
        in_sel   = sel;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    initial begin
        int unsigned exp_cnt_a;
        int unsigned exp_cnt_b;
        logic        exp_stall;

        //           iv   sel  d         ar   br   ir   av   ad        bv   bd        dchk
        vec[0]  = '{1'b1,1'b0,16'h1234,1'b1,1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b1};
        vec[1]  = '{1'b1,1'b1,16'hABCD,1'b1,1'b1,1'b1,1'b1,16'h1234,1'b0,16'h0000,1'b0};
        vec[2]  = '{1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b0,16'h0000,1'b1,16'hABCD,1'b0};
        vec[3]  = '{1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0};
        vec[4]  = '{1'b1,1'b0,16'h0001,1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0};
        vec[5]  = '{1'b1,1'b0,16'h0002,1'b0,1'b1,1'b1,1'b1,16'h0001,1'b0,16'h0000,1'b0};
        vec[6]  = '{1'b1,1'b0,16'h0003,1'b0,1'b1,1'b0,1'b1,16'h0001,1'b0,16'h0000,1'b0};
        vec[7]  = '{1'b1,1'b0,16'h0003,1'b0,1'b1,1'b0,1'b1,16'h0001,1'b0,16'h0000,1'b0};
        vec[8]  = '{1'b1,1'b1,16'h00B1,1'b0,1'b1,1'b1,1'b1,16'h0001,1'b0,16'h0000,1'b0};
        vec[9]  = '{1'b0,1'b1,16'h0000,1'b0,1'b0,1'b1,1'b1,16'h0001,1'b1,16'h00B1,1'b0};
        vec[10] = '{1'b1,1'b0,16'h0003,1'b1,1'b1,1'b0,1'b1,16'h0001,1'b1,16'h00B1,1'b0};
        vec[11] = '{1'b1,1'b0,16'h0003,1'b0,1'b1,1'b1,1'b1,16'h0002,1'b0,16'h0000,1'b0};
        vec[12] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,1'b0,1'b1,16'h0002,1'b0,16'h0000,1'b0};
        vec[13] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h0003,1'b0,16'h0000,1'b0};
        vec[14] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0};
        vec[15] = '{1'b1,1'b0,16'h0011,1'b1,1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0};
        vec[16] = '{1'b1,1'b0,16'h0022,1'b1,1'b1,1'b1,1'b1,16'h0011,1'b0,16'h0000,1'b0};
        vec[17] = '{1'b1,1'b0,16'h0033,1'b1,1'b1,1'b1,1'b1,16'h0022,1'b0,16'h0000,1'b0};
        vec[18] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h0033,1'b0,16'h0000,1'b0};
        vec[19] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0};

        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        #1;
        check("reset_a_valid", 32'(a_valid), 32'd0);
        check("reset_b_valid", 32'(b_valid), 32'd0);
        check("reset_a_data",  32'(a_data),  32'd0);
        check("reset_b_data",  32'(b_data),  32'd0);
`ifdef DEMUX1_2_STATS_EN
        check("reset_cnt_a", 32'(cnt_a), 32'd0);
        check("reset_cnt_b", 32'(cnt_b), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
`endif
        @(posedge clk);

        exp_cnt_a = 0;
        exp_cnt_b = 0;
        exp_stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b0, vec[i].iv, vec[i].sel, vec[i].d, vec[i].ar, vec[i].br);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vec[i].ir));
            check($sformatf("v%0d_a_valid", i),  32'(a_valid),  32'(vec[i].av));
            check($sformatf("v%0d_b_valid", i),  32'(b_valid),  32'(vec[i].bv));
            if (vec[i].av || vec[i].dchk)
                check($sformatf("v%0d_a_data", i), 32'(a_data), 32'(vec[i].ad));
            if (vec[i].bv || vec[i].dchk)
                check($sformatf("v%0d_b_data", i), 32'(b_data), 32'(vec[i].bd));
`ifdef DEMUX1_2_STATS_EN
            check($sformatf("v%0d_cnt_a", i), 32'(cnt_a), exp_cnt_a);
            check($sformatf("v%0d_cnt_b", i), 32'(cnt_b), exp_cnt_b);
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(exp_stall));
`endif
            if (vec[i].iv && vec[i].ir) begin
                if (vec[i].sel) exp_cnt_b++;
                else            exp_cnt_a++;
            end
            exp_stall = vec[i].iv & ~vec[i].ir;
            @(posedge clk);
        end

        // Reset while both FIFOs hold a word and a push is being offered.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'h6666, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
        #1;
        check("prerst_a_valid", 32'(a_valid), 32'd1);
        check("prerst_b_valid", 32'(b_valid), 32'd1);
        check("prerst_a_data",  32'(a_data),  32'h5555);
        check("prerst_b_data",  32'(b_data),  32'h6666);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        check("midrst_a_valid", 32'(a_valid), 32'd0);
        check("midrst_b_valid", 32'(b_valid), 32'd0);
        check("midrst_a_data",  32'(a_data),  32'd0);
        check("midrst_b_data",  32'(b_data),  32'd0);
`ifdef DEMUX1_2_STATS_EN
        check("midrst_cnt_a", 32'(cnt_a), 32'd0);
        check("midrst_cnt_b", 32'(cnt_b), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        check("postrst_a_valid", 32'(a_valid), 32'd0);

`ifdef DEMUX1_2_STATS_EN
        // 65536 back-to-back accepted pushes to A wrap cnt_a to zero.
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, 16'(i), 1'b1, 1'b1);
            if (i == 65535) begin
                #1;
                check("wrap_cnt_a_max", 32'(cnt_a), 32'h0000FFFF);
                check("wrap_in_ready",  32'(in_ready), 32'd1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        #1;
        check("wrap_cnt_a", 32'(cnt_a), 32'd0);
        check("wrap_cnt_b", 32'(cnt_b), 32'd0);
        check("wrap_a_data", 32'(a_data), 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
